// File: rtl/debug_commit_gen.sv
// rtl/debug_commit_gen.sv - commit-record generator for simulation debug/trace
//
// Turns instructions retiring from writeback into one-cycle commit records and
// decides when simulation should stop: on an ebreak-style HALT_INST, on an
// external halt request, or when no instruction has retired for TIMEOUT cycles.
//
// Ports:
//   clock, reset          sole clock (rising edge); asynchronous active-high reset
//   wb_valid/wb_ready     retiring-instruction handshake (ready only while running)
//   wb_pc, wb_inst        PC and encoding of the retiring instruction
//   wb_regWen/Waddr/Wdata GPR write performed by the retiring instruction
//   halt_req              external halt request (level)
//   debug_*               registered commit record, valid for one cycle
//   halt_cause            0 none, 1 ebreak, 2 timeout, 3 external
//   commit_count          number of accepted instructions (wraps at 2^64)
module debug_commit_gen #(
  parameter logic [31:0] HALT_INST = 32'h0010_0073,
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter logic [31:0] TIMEOUT   = 32'd100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_inst,
  input  logic        wb_regWen,
  input  logic [4:0]  wb_regWaddr,
  input  logic [31:0] wb_regWdata,
  input  logic        halt_req,
  output logic        debug_valid,
  output logic        debug_halt,
  output logic [31:0] debug_pc,
  output logic        debug_regWen,
  output logic [4:0]  debug_regWaddr,
  output logic [31:0] debug_regWdata,
  output logic [1:0]  halt_cause,
  output logic [63:0] commit_count
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  localparam logic [1:0] CAUSE_EBREAK   = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;
  localparam logic [1:0] CAUSE_EXTERNAL = 2'd3;

  // Only meaningful when TIMEOUT != 0; the zero case is excluded by timeout_hit.
  localparam logic [31:0] TIMEOUT_LAST = TIMEOUT - 32'd1;

  state_t      state;
  logic [31:0] last_pc;
  logic [31:0] idle_count;
  logic        accept;
  logic        timeout_hit;

  assign wb_ready    = (state == RUN);
  assign accept      = wb_valid && wb_ready;
  assign timeout_hit = (TIMEOUT != 32'd0) && (idle_count == TIMEOUT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= RUN;
      debug_valid    <= 1'b0;
      debug_halt     <= 1'b0;
      debug_pc       <= 32'd0;
      debug_regWen   <= 1'b0;
      debug_regWaddr <= 5'd0;
      debug_regWdata <= 32'd0;
      halt_cause     <= 2'd0;
      commit_count   <= 64'd0;
      idle_count     <= 32'd0;
      last_pc        <= RESET_PC;
    end else if (state == RUN) begin
      if (accept) begin
        debug_valid    <= 1'b1;
        debug_pc       <= wb_pc;
        debug_regWaddr <= wb_regWaddr;
        debug_regWdata <= wb_regWdata;
        // x0 writes are architecturally discarded, so they are not reported.
        debug_regWen   <= wb_regWen && (wb_regWaddr != 5'd0);
        commit_count   <= commit_count + 64'd1;
        last_pc        <= wb_pc;
        idle_count     <= 32'd0;
        // ebreak wins the cause when an external request arrives together.
        if (wb_inst == HALT_INST) begin
          debug_halt <= 1'b1;
          halt_cause <= CAUSE_EBREAK;
          state      <= HALTED;
        end else if (halt_req) begin
          debug_halt <= 1'b1;
          halt_cause <= CAUSE_EXTERNAL;
          state      <= HALTED;
        end else begin
          debug_halt <= 1'b0;
        end
      end else if (halt_req || timeout_hit) begin
        // Synthetic record: reports the last committed PC with no GPR write.
        debug_valid    <= 1'b1;
        debug_halt     <= 1'b1;
        debug_pc       <= last_pc;
        debug_regWen   <= 1'b0;
        debug_regWaddr <= 5'd0;
        debug_regWdata <= 32'd0;
        halt_cause     <= halt_req ? CAUSE_EXTERNAL : CAUSE_TIMEOUT;
        idle_count     <= idle_count + 32'd1;
        state          <= HALTED;
      end else begin
        debug_valid  <= 1'b0;
        debug_halt   <= 1'b0;
        debug_regWen <= 1'b0;
        idle_count   <= idle_count + 32'd1;
      end
    end else begin
      // HALTED: inputs ignored, cause and count frozen until reset.
      debug_valid  <= 1'b0;
      debug_halt   <= 1'b0;
      debug_regWen <= 1'b0;
    end
  end

endmodule

// File: tb/tb_debug_commit_gen.sv
// tb/tb_debug_commit_gen.sv - directed self-checking bench for debug_commit_gen
module tb_debug_commit_gen;

  logic        clock;
  logic        reset;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_pc;
  logic [31:0] wb_inst;
  logic        wb_regWen;
  logic [4:0]  wb_regWaddr;
  logic [31:0] wb_regWdata;
  logic        halt_req;
  logic        debug_valid;
  logic        debug_halt;
  logic [31:0] debug_pc;
  logic        debug_regWen;
  logic [4:0]  debug_regWaddr;
  logic [31:0] debug_regWdata;
  logic [1:0]  halt_cause;
  logic [63:0] commit_count;

  int n_checks;
  int n_pass;
  int n_fail;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  debug_commit_gen #(
    .HALT_INST(32'h0010_0073),
    .RESET_PC (32'h8000_0000),
    .TIMEOUT  (32'd8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_pc         (wb_pc),
    .wb_inst       (wb_inst),
    .wb_regWen     (wb_regWen),
    .wb_regWaddr   (wb_regWaddr),
    .wb_regWdata   (wb_regWdata),
    .halt_req      (halt_req),
    .debug_valid   (debug_valid),
    .debug_halt    (debug_halt),
    .debug_pc      (debug_pc),
    .debug_regWen  (debug_regWen),
    .debug_regWaddr(debug_regWaddr),
    .debug_regWdata(debug_regWdata),
    .halt_cause    (halt_cause),
    .commit_count  (commit_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic wen, input logic [4:0] wa, input logic [31:0] wd);
    wb_valid    = v;
    wb_pc       = pc;
    wb_inst     = inst;
    wb_regWen   = wen;
    wb_regWaddr = wa;
    wb_regWdata = wd;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_fail   = 0;
    reset    = 1'b1;
    halt_req = 1'b0;
    drive(1'b0, 32'd0, NOP, 1'b0, 5'd0, 32'd0);
    #2;
    chk("rst_valid", 64'(debug_valid), 64'd0);
    chk("rst_pc", 64'(debug_pc), 64'd0);
    chk("rst_cause", 64'(halt_cause), 64'd0);
    chk("rst_count", commit_count, 64'd0);
    chk("rst_ready", 64'(wb_ready), 64'd1);
    tick();
    reset = 1'b0;

    // Basic commit with a GPR write.
    drive(1'b1, 32'h8000_0000, NOP, 1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    drive(1'b0, 32'd0, NOP, 1'b0, 5'd0, 32'd0);
    chk("a_valid", 64'(debug_valid), 64'd1);
    chk("a_pc", 64'(debug_pc), 64'h8000_0000);
    chk("a_wen", 64'(debug_regWen), 64'd1);
    chk("a_waddr", 64'(debug_regWaddr), 64'd5);
    chk("a_wdata", 64'(debug_regWdata), 64'hDEAD_BEEF);
    chk("a_halt", 64'(debug_halt), 64'd0);
    chk("a_count", commit_count, 64'd1);
    tick();
    chk("idle_valid", 64'(debug_valid), 64'd0);
    chk("idle_wen", 64'(debug_regWen), 64'd0);
    chk("idle_pc_hold", 64'(debug_pc), 64'h8000_0000);
    chk("idle_wdata_hold", 64'(debug_regWdata), 64'hDEAD_BEEF);

    // Write to x0 is not reported as a GPR write.
    drive(1'b1, 32'h8000_0004, NOP, 1'b1, 5'd0, 32'h0000_0001);
    tick();
    drive(1'b0, 32'd0, NOP, 1'b0, 5'd0, 32'd0);
    chk("x0_valid", 64'(debug_valid), 64'd1);
    chk("x0_wen", 64'(debug_regWen), 64'd0);
    chk("x0_count", commit_count, 64'd2);

    // Three back-to-back commits give three consecutive records.
    drive(1'b1, 32'h8000_0008, NOP, 1'b1, 5'd1, 32'h11);
    tick();
    chk("b2b0_valid", 64'(debug_valid), 64'd1);
    chk("b2b0_pc", 64'(debug_pc), 64'h8000_0008);
    drive(1'b1, 32'h8000_000C, NOP, 1'b1, 5'd2, 32'h22);
    tick();
    chk("b2b1_valid", 64'(debug_valid), 64'd1);
    chk("b2b1_pc", 64'(debug_pc), 64'h8000_000C);
    drive(1'b1, 32'h8000_0014, NOP, 1'b1, 5'd3, 32'h33);
    tick();
    chk("b2b2_valid", 64'(debug_valid), 64'd1);
    chk("b2b2_wdata", 64'(debug_regWdata), 64'h33);
    chk("b2b_count", commit_count, 64'd5);

    // Last commit at 0x80000004, then 8 idle cycles trigger the watchdog.
    drive(1'b1, 32'h8000_0004, NOP, 1'b0, 5'd4, 32'h44);
    tick();
    drive(1'b0, 32'd0, NOP, 1'b0, 5'd0, 32'd0);
    chk("to_last_count", commit_count, 64'd6);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("to_quiet", 64'(debug_valid), 64'd0);
    end
    tick();
    chk("to_valid", 64'(debug_valid), 64'd1);
    chk("to_halt", 64'(debug_halt), 64'd1);
    chk("to_pc", 64'(debug_pc), 64'h8000_0004);
    chk("to_wen", 64'(debug_regWen), 64'd0);
    chk("to_waddr", 64'(debug_regWaddr), 64'd0);
    chk("to_cause", 64'(halt_cause), 64'd2);
    chk("to_ready", 64'(wb_ready), 64'd0);
    chk("to_count", commit_count, 64'd6);
    drive(1'b1, 32'h8000_0100, NOP, 1'b1, 5'd9, 32'h99);
    halt_req = 1'b1;
    tick();
    chk("hlt_valid", 64'(debug_valid), 64'd0);
    chk("hlt_halt", 64'(debug_halt), 64'd0);
    chk("hlt_cause", 64'(halt_cause), 64'd2);
    tick();
    chk("hlt_count", commit_count, 64'd6);
    chk("hlt_valid2", 64'(debug_valid), 64'd0);

    // Asynchronous reset while HALTED takes effect before any clock edge.
    reset = 1'b1;
    halt_req = 1'b0;
    drive(1'b0, 32'd0, NOP, 1'b0, 5'd0, 32'd0);
    #1;
    chk("ar_cause", 64'(halt_cause), 64'd0);
    chk("ar_count", commit_count, 64'd0);
    chk("ar_pc", 64'(debug_pc), 64'd0);
    chk("ar_ready", 64'(wb_ready), 64'd1);
    reset = 1'b0;

    // halt_req alone: synthetic record at RESET_PC.
    halt_req = 1'b1;
    tick();
    chk("hr_valid", 64'(debug_valid), 64'd1);
    chk("hr_halt", 64'(debug_halt), 64'd1);
    chk("hr_pc", 64'(debug_pc), 64'h8000_0000);
    chk("hr_cause", 64'(halt_cause), 64'd3);
    chk("hr_count", commit_count, 64'd0);
    chk("hr_ready", 64'(wb_ready), 64'd0);
    tick();
    chk("hr_once", 64'(debug_valid), 64'd0);
    halt_req = 1'b0;

    // halt_req together with a normal commit marks that record.
    do_reset();
    halt_req = 1'b1;
    drive(1'b1, 32'h8000_0020, NOP, 1'b1, 5'd3, 32'h55);
    tick();
    halt_req = 1'b0;
    drive(1'b0, 32'd0, NOP, 1'b0, 5'd0, 32'd0);
    chk("hc_valid", 64'(debug_valid), 64'd1);
    chk("hc_halt", 64'(debug_halt), 64'd1);
    chk("hc_cause", 64'(halt_cause), 64'd3);
    chk("hc_pc", 64'(debug_pc), 64'h8000_0020);
    chk("hc_wen", 64'(debug_regWen), 64'd1);
    chk("hc_count", commit_count, 64'd1);

    // ebreak with a concurrent halt_req: cause 1, register write still reported.
    do_reset();
    halt_req = 1'b1;
    drive(1'b1, 32'h8000_0010, EBREAK, 1'b1, 5'd7, 32'h77);
    tick();
    halt_req = 1'b0;
    chk("eb_halt", 64'(debug_halt), 64'd1);
    chk("eb_cause", 64'(halt_cause), 64'd1);
    chk("eb_wen", 64'(debug_regWen), 64'd1);
    chk("eb_waddr", 64'(debug_regWaddr), 64'd7);
    chk("eb_ready", 64'(wb_ready), 64'd0);
    drive(1'b1, 32'h8000_0014, NOP, 1'b1, 5'd8, 32'h88);
    tick();
    chk("eb_ignore_valid", 64'(debug_valid), 64'd0);
    chk("eb_ignore_count", commit_count, 64'd1);

    // Reset arriving while a record is on the outputs drops it.
    do_reset();
    drive(1'b1, 32'h8000_0040, NOP, 1'b1, 5'd6, 32'h66);
    tick();
    chk("mr_pre_valid", 64'(debug_valid), 64'd1);
    reset = 1'b1;
    drive(1'b0, 32'd0, NOP, 1'b0, 5'd0, 32'd0);
    #1;
    chk("mr_valid", 64'(debug_valid), 64'd0);
    chk("mr_pc", 64'(debug_pc), 64'd0);
    chk("mr_wdata", 64'(debug_regWdata), 64'd0);
    reset = 1'b0;
    tick();
    chk("mr_no_pulse", 64'(debug_valid), 64'd0);
    chk("mr_ready", 64'(wb_ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/debug_commit_gen.md
DEBUG_COMMIT_GEN -- requirements
Module: debug_commit_gen

Interface
REQ-001 SHALL provide parameter HALT_INST, default 32'h0010_0073, instruction encoding that halts simulation (ebreak).
REQ-002 SHALL provide parameter RESET_PC, default 32'h8000_0000, last-committed PC value after reset.
REQ-003 SHALL provide parameter TIMEOUT, default 32'd100000, idle cycles before watchdog halt; 0 disables the watchdog.
REQ-004 SHALL have ports as follows; clock and reset first; one clock; reset is asynchronous and active-high:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- wb_valid  in  1  writeback stage presents a retiring instruction
- wb_ready  out  1  block accepts a retiring instruction
- wb_pc  in  32  PC of the retiring instruction
- wb_inst  in  32  encoding of the retiring instruction
- wb_regWen  in  1  retiring instruction writes a GPR
- wb_regWaddr  in  5  destination GPR
- wb_regWdata  in  32  write data
- halt_req  in  1  external halt request, level
- debug_valid  out  1  one commit record valid this cycle
- debug_halt  out  1  record terminates simulation
- debug_pc  out  32  record PC
- debug_regWen  out  1  record GPR write
- debug_regWaddr  out  5  record GPR index
- debug_regWdata  out  32  record GPR data
- halt_cause  out  2  0 none, 1 ebreak, 2 timeout, 3 external
- commit_count  out  64  number of accepted instructions

Function
REQ-005 SHALL implement states RUN and HALTED; RUN after reset.
REQ-006 SHALL drive wb_ready = 1 in RUN, 0 in HALTED (combinational from state).
REQ-007 SHALL accept an instruction when wb_valid && wb_ready; all debug_* outputs are registered and appear exactly one cycle after acceptance.
REQ-008 SHALL, for an accepted instruction, drive debug_valid=1 for exactly one cycle with debug_pc=wb_pc, debug_regWaddr=wb_regWaddr, debug_regWdata=wb_regWdata, debug_regWen=wb_regWen && (wb_regWaddr != 0).
REQ-009 SHALL drive debug_valid=0 in any cycle following a cycle without acceptance or synthetic record.
REQ-010 SHALL increment commit_count by 1 per accepted instruction, wrapping modulo 2^64; synthetic records do not count.
REQ-011 SHALL update last_pc to wb_pc on every acceptance.
REQ-012 SHALL, when accepted wb_inst == HALT_INST, set debug_halt=1 on that record, halt_cause=1, state to HALTED; the record still reports its register write.
REQ-013 SHALL, when halt_req=1 in RUN together with an accepted non-HALT_INST instruction, set debug_halt=1 on that record, halt_cause=3, enter HALTED; ebreak takes cause 1 over external.
REQ-014 SHALL, when halt_req=1 in RUN without acceptance, emit a synthetic record next cycle: debug_valid=1, debug_halt=1, debug_pc=last_pc, debug_regWen=0, debug_regWaddr=0, debug_regWdata=0, halt_cause=3, enter HALTED.
REQ-015 SHALL keep a 32-bit idle counter, cleared on acceptance, incremented each RUN cycle without acceptance, not incremented in HALTED.
REQ-016 SHALL, when TIMEOUT != 0 and idle counter == TIMEOUT-1 in a RUN cycle without acceptance and without halt_req, emit a synthetic halt record as REQ-014 but halt_cause=2.
REQ-017 SHALL give priority acceptance > halt_req > timeout within one cycle.
REQ-018 SHALL, in HALTED, hold halt_cause and commit_count, drive debug_valid=0, debug_halt=0, ignore wb_valid and halt_req, and leave HALTED only via reset.
REQ-019 SHALL hold debug_pc/regWaddr/regWdata at their last values when debug_valid=0; debug_regWen and debug_halt are 0 then.

Reset
REQ-020 SHALL, on reset assertion, immediately force state=RUN, debug_valid=0, debug_halt=0, debug_pc=0, debug_regWen=0, debug_regWaddr=0, debug_regWdata=0, halt_cause=0, commit_count=0, idle counter=0, last_pc=RESET_PC.
REQ-021 SHALL, on reset asserted mid-record, drop the in-flight record; no debug_valid pulse after reset deassertion until a new acceptance.

Verification
REQ-022 Accept pc=0x80000000, regWen=1, waddr=5, wdata=0xDEADBEEF -> next cycle debug_valid=1, debug_pc=0x80000000, debug_regWen=1, waddr=5, wdata=0xDEADBEEF, commit_count=1.
REQ-023 Accept waddr=0 with regWen=1 -> debug_regWen=0; back-to-back 3 acceptances -> 3 consecutive debug_valid cycles, commit_count=3.
REQ-024 Accept wb_inst=0x00100073 at pc=0x80000010 -> debug_halt=1, halt_cause=1, wb_ready=0 next cycle; later wb_valid ignored, commit_count unchanged.
REQ-025 TIMEOUT=8, last commit pc=0x80000004, then 8 idle cycles -> one record debug_halt=1, debug_pc=0x80000004, debug_regWen=0, halt_cause=2.
REQ-026 halt_req with simultaneous non-ebreak acceptance -> that record debug_halt=1, halt_cause=3; halt_req alone -> synthetic record pc=last_pc (0x80000000 after reset).
REQ-027 Assert reset asynchronously while HALTED and mid-record -> all outputs 0 immediately, state RUN, wb_ready=1 after deassertion.
